// File: rtl/slt_32b.sv
// slt_32b: registered 32-bit set-less-than built on a ripple-carry subtractor (diff = i0 + ~i1 + 1).
// Optional feature macro SLT_32B_UNSIGNED_EN adds an is_unsigned input selecting an unsigned compare.
module slt_32b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
`ifdef SLT_32B_UNSIGNED_EN
    input  logic        is_unsigned,
`endif
    input  logic [31:0] i0,
    input  logic [31:0] i1,
    output logic [31:0] result,
    output logic        out_valid
);

    // Handshake: a compare is accepted on every rising edge where in_valid=1; there is no
    // ready/backpressure. out_valid pulses for one cycle on the edge after acceptance,
    // and result holds its last value whenever no new compare was accepted.

    logic [31:0] i1_inv;
    logic [31:0] diff;
    logic        carry;
    logic        ovf;
    logic        lt_signed;
    logic        lt;
`ifdef SLT_32B_UNSIGNED_EN
    logic        carry_out;
`endif

    assign i1_inv = ~i1;

    // Full-adder cells chained through a single carry variable, LSB first; the +1 of the
    // two's complement negation enters as the initial carry.
    always_comb begin
        diff  = '0;
        carry = 1'b1;
        for (int k = 0; k < 32; k++) begin
            diff[k] = i0[k] ^ i1_inv[k] ^ carry;
            carry   = (i0[k] & i1_inv[k]) | (carry & (i0[k] ^ i1_inv[k]));
        end
`ifdef SLT_32B_UNSIGNED_EN
        carry_out = carry;
`endif
    end

    // Overflow only when operand signs differ and the difference sign disagrees with i0.
    assign ovf       = (i0[31] != i1[31]) & (diff[31] != i0[31]);
    assign lt_signed = diff[31] ^ ovf;

`ifdef SLT_32B_UNSIGNED_EN
    assign lt = is_unsigned ? ~carry_out : lt_signed;
`else
    assign lt = lt_signed;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= {31'b0, lt};
            end
        end
    end

endmodule

// File: tb/tb_slt_32b.sv
// Directed + random bench for slt_32b; expected results come from a behavioural compare model.
// Define SLT_32B_UNSIGNED_EN for both bench and RTL to exercise the unsigned compare.
module tb_slt_32b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] i0 = '0;
    logic [31:0] i1 = '0;
    logic [31:0] result;
    logic        out_valid;
`ifdef SLT_32B_UNSIGNED_EN
    logic        is_unsigned = 1'b0;
`endif

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    slt_32b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
`ifdef SLT_32B_UNSIGNED_EN
        .is_unsigned(is_unsigned),
`endif
        .i0         (i0),
        .i1         (i1),
        .result     (result),
        .out_valid  (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic u);
        logic lt;
        if (u) lt = (a < b);
        else   lt = ($signed(a) < $signed(b));
        return {31'b0, lt};
    endfunction

    // Drive one pair on the falling edge and queue its expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic u);
        @(negedge clk);
        in_valid = 1'b1;
        i0 = a;
        i1 = b;
`ifdef SLT_32B_UNSIGNED_EN
        is_unsigned = u;
`endif
        exp_q.push_back(model(a, b, u));
    endtask

    task automatic collect(input string tag);
        logic [31:0] e;
        @(posedge clk);
        #1;
        check({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, result, e);
            last_exp = e;
        end
    endtask

    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b);
        issue(a, b, 1'b0);
        collect(tag);
    endtask

    task automatic idle(input string tag, input int n);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_ov"}, {31'b0, out_valid}, 32'd0);
            check({tag, "_hold"}, result, last_exp);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        #3;
        check("reset_result", result, 32'h0);
        check("reset_ov", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release_ov", {31'b0, out_valid}, 32'd0);

        step("s_10_15", 32'd10, 32'd15);
        step("s_m30_m50", -32'sd30, -32'sd50);
        step("s_m100_m50", -32'sd100, -32'sd50);

        step("b_min_16", 32'h8000_0000, 32'h0000_0010);
        step("b_max_eq", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        step("b_max_min", 32'h7FFF_FFFF, 32'h8000_0000);
        step("b_min_max", 32'h8000_0000, 32'h7FFF_FFFF);
        step("b_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
        step("b_zero_eq", 32'h0, 32'h0);

        step("hold_src", 32'h0001_1441, 32'h100B_EFEF);
        idle("hold", 3);

        // Four back-to-back pairs: out_valid must be high on each of the four edges.
        issue(32'd5, 32'd4, 1'b0);         collect("str0");
        issue(32'hFFFF_FFFE, 32'd1, 1'b0); collect("str1");
        issue(32'd1, 32'hFFFF_FFFE, 1'b0); collect("str2");
        issue(32'h4000_0000, 32'hC000_0000, 1'b0); collect("str3");
        idle("str_end", 1);

        for (int k = 0; k < 24; k++) begin
            ra = $urandom();
            rb = (k % 4 == 0) ? ra : $urandom();
            if (k % 5 == 1) ra = {ra[31], 31'($urandom_range(0, 3))};
            issue(ra, rb, 1'b0);
            collect("rand");
        end
        idle("rand_end", 1);

        // Asynchronous reset between edges right after a result of 1.
        step("pre_reset", 32'd10, 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_result", result, 32'h0);
        check("async_rst_ov", {31'b0, out_valid}, 32'd0);
        last_exp = 32'h0;
        @(negedge clk);
        in_valid = 1'b1;
        i0 = 32'd1;
        i1 = 32'd2;
        @(posedge clk);
        #1;
        check("rst_discard_result", result, 32'h0);
        check("rst_discard_ov", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_result", result, 32'h0);
        check("rst_release_ov", {31'b0, out_valid}, 32'd0);
        step("first_after_rst", 32'hFFFF_FFF0, 32'd3);

`ifdef SLT_32B_UNSIGNED_EN
        issue(32'h8000_0000, 32'h0000_0010, 1'b1); collect("u_min_16");
        issue(32'h8000_0000, 32'h0000_0010, 1'b0); collect("s_min_16");
        issue(32'd3, 32'hFFFF_FFFF, 1'b1);         collect("u_3_max");
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); collect("u_eq");
        for (int k = 0; k < 12; k++) begin
            issue($urandom(), $urandom(), 1'($urandom_range(0, 1)));
            collect("u_rand");
        end
`endif
        idle("final", 1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/slt_32b.md
SLT_32B -- requirements
Module: slt_32b

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  high = i0/i1 valid this cycle; comparison accepted.
REQ-005 i0  input  32  left operand, two's complement.
REQ-006 i1  input  32  right operand, two's complement.
REQ-007 result  output  32  registered set-less-than result, zero-extended: {31'b0, lt}.
REQ-008 out_valid  output  1  high for exactly one cycle when result holds a newly computed value.

Function
REQ-009 lt SHALL be 1 iff signed(i0) < signed(i1), else 0; equal operands give 0.
REQ-010 lt SHALL be derived from diff = i0 + ~i1 + 1, computed by a 32-bit ripple-carry chain of full-adder cells.
- Signed mode: lt = diff[31] XOR ovf.
- ovf = (i0[31] != i1[31]) AND (diff[31] != i0[31]).
REQ-011 The comparison SHALL be correct at overflow boundaries:
- 0x80000000 < any other value.
- 0x7FFFFFFF vs 0x80000000 gives 0.
REQ-012 Latency SHALL be 1 cycle: operands sampled at edge N with in_valid=1 give result and out_valid=1 after edge N.
REQ-013 When in_valid=0 at an edge, result SHALL hold its previous value and out_valid SHALL be 0.
REQ-014 Back-to-back in_valid SHALL be accepted every cycle with no stall; there is no backpressure.
REQ-015 result[31:1] SHALL be 0 at all times.
REQ-016 No state machine; the only state is the result and out_valid registers.

Reset
REQ-017 While rst_n=0, result SHALL be 32'h0 and out_valid SHALL be 0, independent of clk.
REQ-018 Reset assertion mid-stream SHALL discard any operand sampled in that cycle.
REQ-019 The first edge after rst_n deasserts SHALL behave per REQ-012/REQ-013.

Configuration
REQ-020 Macro SLT_32B_UNSIGNED_EN SHALL control unsigned-compare support.
- Defined: adds input is_unsigned (1 bit, sampled with in_valid).
  - is_unsigned=1: lt = NOT carry-out of the subtraction chain, i.e. unsigned(i0) < unsigned(i1).
  - is_unsigned=0: signed behaviour per REQ-010.
- Undefined: port absent; signed comparison only.

Verification
REQ-021 Signed cases, each driven with in_valid=1; result 1 cycle later:
- i0=10, i1=15 -> result=1.
- i0=-30, i1=-50 -> result=0.
- i0=-100, i1=-50 -> result=1.
REQ-022 Boundary cases:
- i0=0x80000000, i1=0x00000010 -> result=1.
- i0=i1=0x7FFFFFFF -> result=0.
- i0=0x7FFFFFFF, i1=0x80000000 -> result=0.
REQ-023 i0=0x00011441, i1=0x100BEFEF -> result=1; then in_valid=0 for 3 cycles -> result held at 1, out_valid=0.
REQ-024 Stream 4 operand pairs on consecutive cycles:
- out_valid high 4 consecutive cycles.
- each result matches its own pair, one cycle delayed.
REQ-025 Reset checks:
- Assert rst_n=0 asynchronously between edges after a result of 1 -> result=0 and out_valid=0 immediately.
- Values stay 0 until the first valid compare after release.
REQ-026 With SLT_32B_UNSIGNED_EN defined, i0=0x80000000, i1=0x00000010:
- is_unsigned=1 -> result=0.
- is_unsigned=0 -> result=1.
